hs_link_arbiter: RTL and testbench
==================================

Name: hs_link_arbiter

Overview:
- Shares one req/ack cross-domain handshake link (link_req/link_data/link_ack) among NUM_REQ local producers in the clk_a domain.
- Arbitrates round-robin, captures the winner's data, and drives a 4-phase request toward the far-domain receiver.
- Synchronizes the returning ack, enforces an inter-transfer gap, and recovers from a missing ack by timing out.
- Sits between the producer agents and the link, replacing per-producer driver logic.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- DATA_WIDTH, 4, payload width per requester.
- SYNC_STAGE, 2, flops in the link_ack synchronizer (>=2).
- GAP_CYCLES, 4, minimum idle cycles after a handshake completes before the next link_req rise.
- TIMEOUT_CYCLES, 64, maximum cycles in REQ waiting for ack (>=SYNC_STAGE+2).

Ports:
- clk_a  input  1  sole clock.
- rst_n  input  1  asynchronous active-low reset.
- src_valid  input  NUM_REQ  per-requester data-available level.
- src_data  input  NUM_REQ*DATA_WIDTH  payloads; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- src_ready  output  NUM_REQ  one-hot, combinational; high in the cycle requester i's data is captured.
- link_req  output  1  registered request to the far domain.
- link_data  output  DATA_WIDTH  registered payload; stable from the link_req rise until the next capture.
- link_id  output  $clog2(NUM_REQ)  registered index of the current owner.
- link_ack  input  1  asynchronous ack from the far domain.
- done  output  1  registered one-cycle pulse on ack-rise completion.
- timeout_err  output  1  registered one-cycle pulse on timeout.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, immediate): state=IDLE; link_req=0; link_data=0; link_id=0; done=0; timeout_err=0; synchronizer chain=0; round-robin pointer last=NUM_REQ-1, so requester 0 has first priority; gap counter=0; timeout counter=0. Outputs are forced low even if reset asserts mid-REQ. Reset abandons the current transfer; no done pulse.
- Ack synchronizer: SYNC_STAGE+1 flops. ack_s = stage SYNC_STAGE-1. ack_rise = ack_s & ~stage SYNC_STAGE.
- States:
  - IDLE: if any src_valid, grant the first valid index searching from last+1 modulo NUM_REQ. In the same cycle src_ready[g]=1. On the edge: link_data<=src_data[g], link_id<=g, last<=g, link_req<=1, go to REQ. The request rises on the first edge after valid is seen.
  - REQ: timeout counter increments each cycle.
    - On ack_rise: link_req<=0, done<=1, go to ACK_LOW.
    - Else if counter reaches TIMEOUT_CYCLES-1: link_req<=0, timeout_err<=1, go to ACK_LOW.
    - Ack_rise and timeout in the same cycle: ack wins, done only.
  - ACK_LOW: wait until ack_s==0 (4-phase return), then clear the gap counter and go to GAP.
  - GAP: count GAP_CYCLES cycles, then go to IDLE. With GAP_CYCLES=0, pass straight to IDLE.
- src_ready is 0 in every state except IDLE. src_valid is sampled only in IDLE; deasserting it in other states has no effect.
- ack_rise outside REQ is ignored and produces no outputs.
- Counters are sized $clog2(max+1) and never wrap; each is cleared on state entry.
- link_data and link_id hold their values outside a capture.
- Round-robin wrap: after last=NUM_REQ-1 the search starts at 0.
- Throughput floor per transfer: 1 (capture) + ack latency + ACK_LOW + GAP_CYCLES + 1.

Test Plan:
- Single producer: src_valid[2]=1, data 0xA; ack raised 3 cycles after link_req and held 2 cycles.
  - Required: src_ready=4'b0100 for 1 cycle; link_req=1 with link_data=0xA, link_id=2.
  - link_req falls SYNC_STAGE+1 edges after ack rises; done pulses once.
  - Next link_req rise comes no earlier than GAP_CYCLES+1 cycles after ACK_LOW exits.
- Fairness: all four src_valid held high with an auto-acking receiver model.
  - Required: grant order 0,1,2,3,0,1 and exactly one done per grant.
- Ack never returned:
  - Required: link_req falls after TIMEOUT_CYCLES=64 cycles in REQ; timeout_err pulses once; done stays 0.
  - The next grant goes to the next requester.
- Spurious ack pulse while IDLE or GAP:
  - Required: no done, no link_req change, no state change.
- rst_n asserted 2 cycles into REQ:
  - Required: link_req=0 and busy=0 immediately (asynchronous).
  - After release, requester 0 is granted first even if requester 3 owned the aborted transfer.
- Ack held high past the done pulse:
  - Required: busy stays 1 in ACK_LOW until ack_s falls; no new src_ready until GAP completes.

Source files
------------

// File: rtl/hs_link_arbiter.sv
// Round-robin arbiter that shares one 4-phase req/ack link among NUM_REQ producers.
// It synchronizes the far-domain ack, enforces an idle gap after each transfer, and times out on a lost ack.
module hs_link_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 4,
  parameter int SYNC_STAGE     = 2,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                             clk_a,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               src_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    src_data,
  output logic [NUM_REQ-1:0]               src_ready,
  output logic                             link_req,
  output logic [DATA_WIDTH-1:0]            link_data,
  output logic [$clog2(NUM_REQ)-1:0]       link_id,
  input  logic                             link_ack,
  output logic                             done,
  output logic                             timeout_err,
  output logic                             busy
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    ACK_LOW = 2'd2,
    GAP     = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [SYNC_STAGE:0]     sync_q, sync_d;
  logic                    link_req_q, link_req_d;
  logic [DATA_WIDTH-1:0]   link_data_q, link_data_d;
  logic [IW-1:0]           link_id_q, link_id_d;
  logic [IW-1:0]           last_q, last_d;
  logic                    done_q, done_d;
  logic                    timeout_q, timeout_d;
  logic [TW-1:0]           tcnt_q, tcnt_d;
  logic [GW-1:0]           gcnt_q, gcnt_d;

  logic                    ack_s;
  logic                    ack_rise;
  logic [IW-1:0]           grant;
  logic                    grant_vld;

  // Stage 0 is the metastability catcher; the extra top stage only serves edge detection.
  assign sync_d   = {sync_q[SYNC_STAGE-1:0], link_ack};
  assign ack_s    = sync_q[SYNC_STAGE-1];
  assign ack_rise = ack_s & ~sync_q[SYNC_STAGE];

  // First valid requester after the previous owner, wrapping modulo NUM_REQ.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!grant_vld && src_valid[(int'(last_q) + k) % NUM_REQ]) begin
        grant_vld = 1'b1;
        grant     = IW'((int'(last_q) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    link_req_d  = link_req_q;
    link_data_d = link_data_q;
    link_id_d   = link_id_q;
    last_d      = last_q;
    done_d      = 1'b0;
    timeout_d   = 1'b0;
    tcnt_d      = tcnt_q;
    gcnt_d      = gcnt_q;
    src_ready   = '0;
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          src_ready[grant] = 1'b1;
          link_data_d      = src_data[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
          link_id_d        = grant;
          last_d           = grant;
          link_req_d       = 1'b1;
          tcnt_d           = '0;
          state_d          = REQ;
        end
      end
      REQ: begin
        // An ack arriving in the timeout cycle still counts as a clean completion.
        if (ack_rise) begin
          link_req_d = 1'b0;
          done_d     = 1'b1;
          state_d    = ACK_LOW;
        end else if (tcnt_q == TO_LAST) begin
          link_req_d = 1'b0;
          timeout_d  = 1'b1;
          state_d    = ACK_LOW;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      ACK_LOW: begin
        if (!ack_s) begin
          gcnt_d  = '0;
          state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        if (gcnt_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gcnt_d = gcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_a or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sync_q      <= '0;
      link_req_q  <= 1'b0;
      link_data_q <= '0;
      link_id_q   <= '0;
      last_q      <= IW'(NUM_REQ - 1);
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      tcnt_q      <= '0;
      gcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      link_req_q  <= link_req_d;
      link_data_q <= link_data_d;
      link_id_q   <= link_id_d;
      last_q      <= last_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      tcnt_q      <= tcnt_d;
      gcnt_q      <= gcnt_d;
    end
  end

  assign link_req    = link_req_q;
  assign link_data   = link_data_q;
  assign link_id     = link_id_q;
  assign done        = done_q;
  assign timeout_err = timeout_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_hs_link_arbiter.sv
// Directed bench for hs_link_arbiter: single transfer, fairness, timeout, reset abort,
// held ack and spurious ack pulses, with hand-computed expectations.
module tb_hs_link_arbiter;

  logic        clk_a = 1'b0;
  logic        rst_n;
  logic [3:0]  src_valid;
  logic [15:0] src_data;
  logic [3:0]  src_ready;
  logic        link_req;
  logic [3:0]  link_data;
  logic [1:0]  link_id;
  logic        link_ack;
  logic        done;
  logic        timeout_err;
  logic        busy;

  logic        ack_man;
  logic        ack_auto;
  logic        auto_en;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  int to_cnt   = 0;

  logic [1:0] exp_q[$];

  hs_link_arbiter #(
    .NUM_REQ(4), .DATA_WIDTH(4), .SYNC_STAGE(2), .GAP_CYCLES(4), .TIMEOUT_CYCLES(64)
  ) dut (
    .clk_a(clk_a), .rst_n(rst_n), .src_valid(src_valid), .src_data(src_data),
    .src_ready(src_ready), .link_req(link_req), .link_data(link_data), .link_id(link_id),
    .link_ack(link_ack), .done(done), .timeout_err(timeout_err), .busy(busy)
  );

  // clock / reset-independent infrastructure
  always #5 clk_a = ~clk_a;

  assign link_ack = auto_en ? ack_auto : ack_man;

  // Receiver model: ack follows req half a cycle later.
  always @(negedge clk_a) ack_auto = link_req;

  always @(negedge clk_a) begin
    if (done === 1'b1) done_cnt++;
    if (timeout_err === 1'b1) to_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // driver / checker tasks
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_a);
    #1;
  endtask

  task automatic wait_req(input logic level, input int max_cycles, input string tag);
    int n;
    n = 0;
    while (link_req !== level && n < max_cycles) begin
      step();
      n++;
    end
    check_eq(tag, link_req, level);
  endtask

  task automatic wait_idle(input int max_cycles, input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < max_cycles) begin
      step();
      n++;
    end
    check_eq(tag, busy, 1'b0);
  endtask

  initial begin
    int n;
    int d0;
    int t0;
    logic [3:0] data_tbl [4];
    logic [1:0] eid;

    data_tbl[0] = 4'h1; data_tbl[1] = 4'h5; data_tbl[2] = 4'hA; data_tbl[3] = 4'h3;
    rst_n     = 1'b0;
    src_valid = '0;
    src_data  = 16'h3A51;
    ack_man   = 1'b0;
    auto_en   = 1'b0;
    repeat (3) step();
    check_eq("rst_link_req", link_req, 1'b0);
    check_eq("rst_link_data", link_data, 4'h0);
    check_eq("rst_link_id", link_id, 2'd0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_timeout", timeout_err, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_ready", src_ready, 4'b0000);
    rst_n = 1'b1;
    step();

    // Single producer on requester 2.
    src_valid = 4'b0100;
    #1;
    check_eq("t1_ready", src_ready, 4'b0100);
    step();
    check_eq("t1_req", link_req, 1'b1);
    check_eq("t1_data", link_data, 4'hA);
    check_eq("t1_id", link_id, 2'd2);
    check_eq("t1_busy", busy, 1'b1);
    src_valid = 4'b0000;
    #1;
    check_eq("t1_ready_req", src_ready, 4'b0000);
    step();
    step();
    ack_man = 1'b1;
    step();
    check_eq("t1_req_e1", link_req, 1'b1);
    step();
    check_eq("t1_req_e2", link_req, 1'b1);
    check_eq("t1_done_e2", done, 1'b0);
    ack_man = 1'b0;
    step();
    check_eq("t1_req_e3", link_req, 1'b0);
    check_eq("t1_done_e3", done, 1'b1);
    src_valid = 4'b0001;
    n = 0;
    while (link_req !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check_eq("t1_gap_cycles", n, 7);
    check_eq("t1_next_id", link_id, 2'd0);
    check_eq("t1_next_data", link_data, 4'h1);
    src_valid = 4'b0000;
    auto_en   = 1'b1;
    wait_idle(40, "t1_idle");
    auto_en = 1'b0;
    check_eq("t1_done_count", done_cnt, 2);
    check_eq("t1_timeout_count", to_cnt, 0);

    // Fairness with all requesters active from reset.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    d0 = done_cnt;
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    src_valid = 4'b1111;
    auto_en   = 1'b1;
    for (int k = 0; k < 6; k++) begin
      wait_req(1'b1, 40, "fair_rise");
      eid = exp_q.pop_front();
      check_eq("fair_id", link_id, eid);
      check_eq("fair_data", link_data, data_tbl[eid]);
      if (k == 5) src_valid = 4'b0000;
      wait_req(1'b0, 40, "fair_fall");
    end
    wait_idle(40, "fair_idle");
    auto_en = 1'b0;
    check_eq("fair_done_count", done_cnt - d0, 6);

    // Ack never returned: timeout after 64 REQ cycles.
    d0 = done_cnt;
    t0 = to_cnt;
    src_valid = 4'b1100;
    #1;
    check_eq("to_ready", src_ready, 4'b0100);
    step();
    check_eq("to_req", link_req, 1'b1);
    check_eq("to_id", link_id, 2'd2);
    src_valid = 4'b0000;
    n = 0;
    while (link_req === 1'b1 && n < 100) begin
      step();
      n++;
    end
    check_eq("to_req_cycles", n, 64);
    check_eq("to_err_pulse", timeout_err, 1'b1);
    step();
    check_eq("to_err_clear", timeout_err, 1'b0);
    src_valid = 4'b1111;
    #1;
    n = 0;
    while (src_ready === 4'b0000 && n < 20) begin
      step();
      n++;
    end
    check_eq("to_next_ready", src_ready, 4'b1000);
    step();
    check_eq("to_next_id", link_id, 2'd3);
    check_eq("to_next_req", link_req, 1'b1);
    check_eq("to_err_count", to_cnt - t0, 1);
    check_eq("to_done_count", done_cnt, d0);

    // Reset two cycles into requester 3's REQ.
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("ar_req", link_req, 1'b0);
    check_eq("ar_busy", busy, 1'b0);
    check_eq("ar_id", link_id, 2'd0);
    #3;
    rst_n = 1'b1;
    #1;
    check_eq("ar_ready", src_ready, 4'b0001);
    step();
    check_eq("ar_grant_id", link_id, 2'd0);
    check_eq("ar_grant_req", link_req, 1'b1);
    check_eq("ar_no_done", done_cnt, d0);

    // Ack held high long after the done pulse; spurious pulse during GAP.
    src_valid = 4'b0000;
    ack_man   = 1'b1;
    step();
    step();
    check_eq("ah_req_hi", link_req, 1'b1);
    step();
    check_eq("ah_req_lo", link_req, 1'b0);
    check_eq("ah_done", done, 1'b1);
    src_valid = 4'b0010;
    for (int k = 0; k < 8; k++) begin
      step();
      check_eq("ah_busy", busy, 1'b1);
      check_eq("ah_ready", src_ready, 4'b0000);
    end
    ack_man = 1'b0;
    d0 = done_cnt;
    n = 0;
    while (src_ready === 4'b0000 && n < 20) begin
      step();
      n++;
      if (n == 4) ack_man = 1'b1;
      if (n == 5) ack_man = 1'b0;
    end
    check_eq("ah_release_cycles", n, 7);
    check_eq("ah_release_ready", src_ready, 4'b0010);
    check_eq("gap_spurious_done", done_cnt, d0);
    auto_en = 1'b1;
    step();
    src_valid = 4'b0000;
    check_eq("ah_next_id", link_id, 2'd1);
    check_eq("ah_next_req", link_req, 1'b1);
    wait_req(1'b0, 40, "ah_next_fall");
    wait_idle(40, "ah_next_idle");
    auto_en = 1'b0;
    check_eq("ah_next_done", done_cnt, d0 + 1);

    // Spurious ack while IDLE.
    d0 = done_cnt;
    t0 = to_cnt;
    ack_man = 1'b1;
    repeat (3) step();
    check_eq("sp_busy_hi", busy, 1'b0);
    ack_man = 1'b0;
    repeat (5) step();
    check_eq("sp_busy", busy, 1'b0);
    check_eq("sp_req", link_req, 1'b0);
    check_eq("sp_done", done_cnt, d0);
    check_eq("sp_timeout", to_cnt, t0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
